reset_pulse_gen: RTL and testbench

- Clock-domain consumer of the generated clock: drives a programmable DUT reset pulse, cycle-aligned to that clock, for the co-emulation harness.
- On its own reset it issues a fixed power-on pulse.
- It then accepts delay/duration/delay requests through a valid/ready handshake.
- Provides a free-running cycle counter and a completed-pulse counter for the HVL proxy.

---
 rtl/reset_pulse_gen.sv | 155 +++++++++++++++
 tb/tb_reset_pulse_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reset_pulse_gen.sv
// Programmable reset pulse generator: fixed power-on pulse, then pre-delay /
// duration / post-delay requests accepted over a valid/ready handshake.
module reset_pulse_gen #(
  parameter int CNT_WIDTH          = 16,
  parameter int RESET_ACTIVE_LEVEL = 1,
  parameter int POWERON_CYCLES     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CNT_WIDTH-1:0] req_pre_delay,
  input  logic [CNT_WIDTH-1:0] req_duration,
  input  logic [CNT_WIDTH-1:0] req_post_delay,
  input  logic                 abort,
  output logic                 dut_reset,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 aborted,
  output logic [63:0]          cycle_count,
  output logic [15:0]          pulse_count
);

  typedef enum logic [2:0] {
    S_POWERON = 3'd0,
    S_IDLE    = 3'd1,
    S_PRE     = 3'd2,
    S_ASSERT  = 3'd3,
    S_POST    = 3'd4
  } state_t;

  localparam logic                 ACT      = (RESET_ACTIVE_LEVEL != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_WIDTH-1:0] PON_LAST = CNT_WIDTH'(POWERON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] pre_q, dur_q, post_q;
  logic                 lat_q;
  logic                 zero_pend_q;
  logic                 dut_reset_q, ready_q, busy_q, done_q, aborted_q;
  logic [63:0]          cycle_q;
  logic [15:0]          pulse_q;

  // lat_q holds the first phase of a request for one extra cycle, which gives
  // the one-clock offset between the handshake edge and the phase windows.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_POWERON;
      cnt_q       <= '0;
      pre_q       <= '0;
      dur_q       <= '0;
      post_q      <= '0;
      lat_q       <= 1'b0;
      zero_pend_q <= 1'b0;
      dut_reset_q <= ACT;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cycle_q     <= 64'd0;
      pulse_q     <= 16'd0;
    end else begin
      cycle_q   <= cycle_q + 64'd1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        S_POWERON: begin
          if (cnt_q == PON_LAST) begin
            state_q     <= S_IDLE;
            dut_reset_q <= ~ACT;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            if (pulse_q != 16'hFFFF) pulse_q <= pulse_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        S_IDLE: begin
          if (zero_pend_q) begin
            done_q      <= 1'b1;
            zero_pend_q <= 1'b0;
          end
          if (req_valid && ready_q) begin
            pre_q  <= req_pre_delay;
            dur_q  <= req_duration;
            post_q <= req_post_delay;
            cnt_q  <= '0;
            lat_q  <= 1'b1;
            if (req_pre_delay != '0 || req_duration != '0 || req_post_delay != '0) begin
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              if (req_pre_delay != '0)     state_q <= S_PRE;
              else if (req_duration != '0) state_q <= S_ASSERT;
              else                         state_q <= S_POST;
            end else begin
              zero_pend_q <= 1'b1;
            end
          end
        end
        S_PRE, S_ASSERT, S_POST: begin
          if (abort) begin
            state_q     <= S_IDLE;
            dut_reset_q <= ~ACT;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            aborted_q   <= 1'b1;
            lat_q       <= 1'b0;
          end else if (lat_q) begin
            lat_q <= 1'b0;
            if (state_q == S_ASSERT) dut_reset_q <= ACT;
          end else if ((state_q == S_PRE    && cnt_q == pre_q - ONE) ||
                       (state_q == S_ASSERT && cnt_q == dur_q - ONE) ||
                       (state_q == S_POST   && cnt_q == post_q - ONE)) begin
            cnt_q <= '0;
            if (state_q == S_PRE && dur_q != '0) begin
              state_q     <= S_ASSERT;
              dut_reset_q <= ACT;
            end else if (state_q != S_POST && post_q != '0) begin
              state_q     <= S_POST;
              dut_reset_q <= ~ACT;
            end else begin
              state_q     <= S_IDLE;
              dut_reset_q <= ~ACT;
              ready_q     <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
            if (state_q == S_ASSERT && pulse_q != 16'hFFFF) pulse_q <= pulse_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          state_q     <= S_POWERON;
          cnt_q       <= '0;
          dut_reset_q <= ACT;
          ready_q     <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign dut_reset   = dut_reset_q;
  assign busy        = busy_q;
  assign done_pulse  = done_q;
  assign aborted     = aborted_q;
  assign cycle_count = cycle_q;
  assign pulse_count = pulse_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed bench for reset_pulse_gen; a second instance built active-low
// shares all stimulus and must show the complementary dut_reset.
module tb_reset_pulse_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_pre_delay = 16'd0, req_duration = 16'd0, req_post_delay = 16'd0;
  logic        abort = 1'b0;

  logic        req_ready, dut_reset, busy, done_pulse, aborted;
  logic [63:0] cycle_count;
  logic [15:0] pulse_count;

  logic        n_req_ready, n_dut_reset, n_busy, n_done_pulse, n_aborted;
  logic [63:0] n_cycle_count;
  logic [15:0] n_pulse_count;

  int checks = 0;
  int errors = 0;

  reset_pulse_gen #(.CNT_WIDTH(16), .RESET_ACTIVE_LEVEL(1), .POWERON_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_pre_delay(req_pre_delay), .req_duration(req_duration), .req_post_delay(req_post_delay),
    .abort(abort), .dut_reset(dut_reset), .busy(busy), .done_pulse(done_pulse),
    .aborted(aborted), .cycle_count(cycle_count), .pulse_count(pulse_count));

  reset_pulse_gen #(.CNT_WIDTH(16), .RESET_ACTIVE_LEVEL(0), .POWERON_CYCLES(16)) dut_n (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(n_req_ready),
    .req_pre_delay(req_pre_delay), .req_duration(req_duration), .req_post_delay(req_post_delay),
    .abort(abort), .dut_reset(n_dut_reset), .busy(n_busy), .done_pulse(n_done_pulse),
    .aborted(n_aborted), .cycle_count(n_cycle_count), .pulse_count(n_pulse_count));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rst(input string tag, input logic exp_high);
    chk(tag, {63'd0, dut_reset}, {63'd0, exp_high});
    chk({tag, "_n"}, {63'd0, n_dut_reset}, {63'd0, ~exp_high});
  endtask

  task automatic poweron_seq(input logic [15:0] exp_pulses);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("pon_cycle", cycle_count, 64'(i));
      chk_rst("pon_rst", i < 16);
      chk("pon_done", {63'd0, done_pulse}, {63'd0, i == 16});
    end
    chk("pon_pulses", {48'd0, pulse_count}, {48'd0, exp_pulses});
    chk("pon_ready", {63'd0, req_ready}, 64'd1);
    chk("pon_aborted", {63'd0, aborted}, 64'd0);
    tick();
    chk("pon_done_clr", {63'd0, done_pulse}, 64'd0);
  endtask

  task automatic request(input logic [15:0] p, input logic [15:0] d, input logic [15:0] q);
    req_pre_delay = p; req_duration = d; req_post_delay = q; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and power-on pulse
    repeat (3) tick();
    chk_rst("rst_dut", 1'b1);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1);
    chk("rst_done", {63'd0, done_pulse}, 64'd0);
    chk("rst_cycle", cycle_count, 64'd0);
    chk("rst_pulses", {48'd0, pulse_count}, 64'd0);
    reset = 1'b0;
    poweron_seq(16'd1);

    // p=2 d=5 q=3; req_valid held high mid-request must be ignored
    request(16'd2, 16'd5, 16'd3);
    chk("s2_busy0", {63'd0, busy}, 64'd1);
    chk("s2_ready0", {63'd0, req_ready}, 64'd0);
    chk_rst("s2_rst0", 1'b0);
    for (int j = 1; j <= 11; j++) begin
      req_valid = (j >= 2 && j <= 9);
      tick();
      chk_rst("s2_rst", j >= 3 && j < 8);
      chk("s2_done", {63'd0, done_pulse}, {63'd0, j == 11});
      chk("s2_busy", {63'd0, busy}, {63'd0, j < 11});
      chk("s2_ready", {63'd0, req_ready}, {63'd0, j == 11});
    end
    req_valid = 1'b0;
    chk("s2_pulses", {48'd0, pulse_count}, 64'd2);
    chk("s2_aborted", {63'd0, aborted}, 64'd0);
    tick();

    // all-zero request, then back-to-back d=1 on its done edge
    request(16'd0, 16'd0, 16'd0);
    chk("s3_ready", {63'd0, req_ready}, 64'd1);
    chk("s3_busy", {63'd0, busy}, 64'd0);
    chk("s3_done0", {63'd0, done_pulse}, 64'd0);
    chk_rst("s3_rst0", 1'b0);
    request(16'd0, 16'd1, 16'd0);
    chk("s3_done1", {63'd0, done_pulse}, 64'd1);
    chk("s3_ab1", {63'd0, aborted}, 64'd0);
    chk_rst("s3_rst1", 1'b0);
    chk("s3_busy1", {63'd0, busy}, 64'd1);
    tick();
    chk_rst("s3_rst2", 1'b1);
    chk("s3_done2", {63'd0, done_pulse}, 64'd0);
    tick();
    chk_rst("s3_rst3", 1'b0);
    chk("s3_done3", {63'd0, done_pulse}, 64'd1);
    chk("s3_pulses", {48'd0, pulse_count}, 64'd3);
    tick();

    // p=0 d=10 q=4, abort during third asserted cycle
    request(16'd0, 16'd10, 16'd4);
    chk_rst("s4_rst0", 1'b0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk_rst("s4_rst", 1'b1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_rst("s4_rst_ab", 1'b0);
    chk("s4_done", {63'd0, done_pulse}, 64'd1);
    chk("s4_aborted", {63'd0, aborted}, 64'd1);
    chk("s4_pulses", {48'd0, pulse_count}, 64'd3);
    chk("s4_ready", {63'd0, req_ready}, 64'd1);
    tick();
    chk("s4_done_clr", {63'd0, done_pulse}, 64'd0);
    chk("s4_ab_clr", {63'd0, aborted}, 64'd0);

    // reset in the middle of a d=100 pulse
    request(16'd0, 16'd100, 16'd0);
    repeat (5) tick();
    chk_rst("s5_mid", 1'b1);
    reset = 1'b1;
    tick();
    chk_rst("s5_rst", 1'b1);
    chk("s5_cycle", cycle_count, 64'd0);
    chk("s5_pulses", {48'd0, pulse_count}, 64'd0);
    chk("s5_busy", {63'd0, busy}, 64'd1);
    chk("s5_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b0;
    poweron_seq(16'd1);

    // cycle counter wrap
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFE;
    release dut.cycle_q;
    tick();
    chk("wrap_max", cycle_count, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap_zero", cycle_count, 64'd0);
    tick();
    chk("wrap_one", cycle_count, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
